// File: rtl/program_loader_pkg.sv
// Shared definitions for the boot-time program loader: FSM encoding and imem base address.
package program_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HDR0  = 3'd1,
    ST_HDR1  = 3'd2,
    ST_LOAD  = 3'd3,
    ST_CHECK = 3'd4,
    ST_DONE  = 3'd5,
    ST_ERROR = 3'd6
  } loader_state_t;

  localparam logic [31:0] IMEM_BASE = 32'h0000_0000;

endpackage

// File: rtl/program_loader_byte_assembler.sv
// Packs a little-endian byte stream into 32-bit words; word/word_valid update on the 4th byte.
module program_loader_byte_assembler (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        last_byte,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [23:0] shift_q;
  logic [1:0]  cnt_q;

  assign last_byte = byte_valid && (cnt_q == 2'd3);

  // word holds its last value across clear so imem_wdata never glitches on reload
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shift_q    <= '0;
      cnt_q      <= '0;
      word_valid <= 1'b0;
      word       <= '0;
    end else begin
      word_valid <= last_byte;
      if (clear) begin
        shift_q <= '0;
        cnt_q   <= '0;
      end else if (byte_valid) begin
        cnt_q   <= cnt_q + 2'd1;
        shift_q <= {byte_data, shift_q[23:8]};
        if (last_byte) word <= {byte_data, shift_q};
      end
    end
  end

endmodule

// File: rtl/program_loader.sv
// Boot loader: header/length check, word writes to imem, XOR checksum verify, core hold control.
// state | meaning
// IDLE  | counters cleared, about to accept a header
// HDR0  | waiting for word count low byte
// HDR1  | waiting for word count high byte, length checked
// LOAD  | streaming data bytes into imem words
// CHECK | waiting for the XOR checksum byte
// DONE  | image verified, core released
// ERROR | length or checksum failure, core held
module program_loader
  import program_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        reload,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_hold,
  output logic        load_done,
  output logic        load_error
);

  localparam int          IDX_W     = ADDR_WIDTH + 1;
  localparam logic [16:0] MAX_WORDS = 17'd1 << ADDR_WIDTH;

  loader_state_t state, state_nxt;

  logic [7:0]       n_lo;
  logic [15:0]      n_words;
  logic [IDX_W-1:0] word_idx;
  logic [7:0]       checksum;
  logic             xfer, load_byte, word_last_byte, last_word;
  logic [16:0]      hdr_n;
  logic             in_ready_d, cpu_hold_d, load_done_d, load_error_d;

  assign xfer      = in_valid && in_ready;
  assign load_byte = xfer && (state == ST_LOAD);
  assign hdr_n     = {1'b0, in_data, n_lo};
  assign last_word = (17'(word_idx) + 17'd1) == {1'b0, n_words};

  program_loader_byte_assembler u_asm (
    .clk        (clk),
    .reset      (reset),
    .clear      (state == ST_IDLE),
    .byte_valid (load_byte),
    .byte_data  (in_data),
    .last_byte  (word_last_byte),
    .word_valid (imem_we),
    .word       (imem_wdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  state_nxt = ST_HDR0;
      ST_HDR0:  if (xfer) state_nxt = ST_HDR1;
      ST_HDR1:
        if (xfer) begin
          if (hdr_n > MAX_WORDS) state_nxt = ST_ERROR;
          else if (hdr_n == 17'd0) state_nxt = ST_CHECK;
          else state_nxt = ST_LOAD;
        end
      ST_LOAD:  if (word_last_byte && last_word) state_nxt = ST_CHECK;
      ST_CHECK: if (xfer) state_nxt = (in_data == checksum) ? ST_DONE : ST_ERROR;
      ST_DONE, ST_ERROR: if (reload) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // outputs are decoded from the next state so the registered copies line up with state
  always_comb begin
    in_ready_d   = (state_nxt == ST_HDR0) || (state_nxt == ST_HDR1) ||
                   (state_nxt == ST_LOAD) || (state_nxt == ST_CHECK);
    cpu_hold_d   = (state_nxt != ST_DONE);
    load_done_d  = (state_nxt == ST_DONE);
    load_error_d = (state_nxt == ST_ERROR);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_ready   <= 1'b0;
      cpu_hold   <= 1'b1;
      load_done  <= 1'b0;
      load_error <= 1'b0;
      imem_addr  <= '0;
      n_lo       <= '0;
      n_words    <= '0;
      word_idx   <= '0;
      checksum   <= '0;
    end else begin
      in_ready   <= in_ready_d;
      cpu_hold   <= cpu_hold_d;
      load_done  <= load_done_d;
      load_error <= load_error_d;
      if (state == ST_IDLE) begin
        word_idx <= '0;
        checksum <= '0;
      end
      if (xfer && state == ST_HDR0) n_lo <= in_data;
      if (xfer && state == ST_HDR1) n_words <= {in_data, n_lo};
      if (load_byte) begin
        checksum <= checksum ^ in_data;
        if (word_last_byte) begin
          imem_addr <= IMEM_BASE + (32'(word_idx) << 2);
          word_idx  <= word_idx + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Randomized scoreboard bench for program_loader: expected imem writes queued, checked on imem_we.
module tb_program_loader;

  logic        clk = 1'b0;
  logic        reset, reload, in_valid;
  logic [7:0]  in_data;
  logic        in_ready, imem_we, cpu_hold, load_done, load_error;
  logic [31:0] imem_addr, imem_wdata;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  logic [7:0]  data_q[$];
  int          vectors = 0;
  int          fails   = 0;

  program_loader #(.ADDR_WIDTH(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .reload     (reload),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_hold   (cpu_hold),
    .load_done  (load_done),
    .load_error (load_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor: every write strobe must match the oldest expected write
  always @(negedge clk) begin
    if (reset === 1'b1 && imem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write_addr", imem_addr, 32'hFFFF_FFFF);
      end else begin
        wr_t w;
        w = exp_q.pop_front();
        chk("write_addr", imem_addr, w.addr);
        chk("write_data", imem_wdata, w.data);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int t = 0;
    if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
    while (in_ready !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (in_ready !== 1'b1) begin
      chk("in_ready_timeout", {31'b0, in_ready}, 32'd1);
      return;
    end
    in_valid = 1'b1;
    in_data  = b;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = $urandom();
  endtask

  task automatic fill_random(input int n_bytes);
    data_q.delete();
    for (int i = 0; i < n_bytes; i++) data_q.push_back(8'($urandom()));
  endtask

  // reference: word i is bytes 4i..4i+3 little-endian at byte address 4i
  task automatic run_frame(input int n, input bit bad, input bit gaps);
    logic [7:0] x;
    logic [15:0] n16;
    x   = 8'h00;
    n16 = 16'(n);
    foreach (data_q[i]) x ^= data_q[i];
    if (n <= 256) begin
      for (int i = 0; i < n; i++) begin
        wr_t w;
        w.addr = 32'(i * 4);
        w.data = {data_q[4*i+3], data_q[4*i+2], data_q[4*i+1], data_q[4*i]};
        exp_q.push_back(w);
      end
    end
    send_byte(n16[7:0], gaps);
    send_byte(n16[15:8], gaps);
    if (n > 256) begin
      chk("len_err_flag", {31'b0, load_error}, 32'd1);
      chk("len_err_ready", {31'b0, in_ready}, 32'd0);
      chk("len_err_hold", {31'b0, cpu_hold}, 32'd1);
      repeat (3) @(negedge clk);
      chk("len_err_writes", 32'(exp_q.size()), 32'd0);
      return;
    end
    foreach (data_q[i]) send_byte(data_q[i], gaps);
    send_byte(bad ? (x ^ 8'h01) : x, gaps);
    chk("done_flag", {31'b0, load_done}, {31'b0, !bad});
    chk("error_flag", {31'b0, load_error}, {31'b0, bad});
    chk("cpu_hold", {31'b0, cpu_hold}, {31'b0, bad});
    chk("ready_after", {31'b0, in_ready}, 32'd0);
    repeat (2) @(negedge clk);
    chk("pending_writes", 32'(exp_q.size()), 32'd0);
    chk("flags_sticky", {30'b0, load_done, load_error}, {30'b0, !bad, bad});
  endtask

  task automatic do_reload();
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    chk("reload_hold", {31'b0, cpu_hold}, 32'd1);
    chk("reload_flags", {30'b0, load_done, load_error}, 32'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_ready"}, {31'b0, in_ready}, 32'd0);
    chk({tag, "_we"}, {31'b0, imem_we}, 32'd0);
    chk({tag, "_addr"}, imem_addr, 32'd0);
    chk({tag, "_wdata"}, imem_wdata, 32'd0);
    chk({tag, "_hold"}, {31'b0, cpu_hold}, 32'd1);
    chk({tag, "_flags"}, {30'b0, load_done, load_error}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] t1[8];
    logic [7:0] img[$];
    reset    = 1'b0;
    reload   = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    reset = 1'b1;

    t1 = '{8'h05, 8'h00, 8'h08, 8'h20, 8'h20, 8'h40, 8'h09, 8'h01};
    data_q.delete();
    foreach (t1[i]) data_q.push_back(t1[i]);
    run_frame(2, 1'b0, 1'b0);
    do_reload();
    run_frame(2, 1'b1, 1'b0);
    do_reload();

    data_q.delete();
    run_frame(0, 1'b0, 1'b0);
    do_reload();

    fill_random(4 * 257);
    run_frame(257, 1'b0, 1'b0);
    do_reload();
    fill_random(4 * 256);
    run_frame(256, 1'b0, 1'b0);
    chk("last_addr", imem_addr, 32'h0000_03FC);
    do_reload();

    fill_random(4 * 7);
    img = data_q;
    run_frame(7, 1'b0, 1'b1);
    do_reload();
    data_q = img;
    run_frame(7, 1'b0, 1'b0);
    do_reload();
    for (int k = 0; k < 3; k++) begin
      fill_random(4 * $urandom_range(1, 6));
      run_frame(data_q.size() / 4, ($urandom_range(0, 3) == 0), 1'b1);
      do_reload();
    end

    fill_random(12);
    begin
      wr_t w;
      w.addr = 32'h0;
      w.data = {data_q[3], data_q[2], data_q[1], data_q[0]};
      exp_q.push_back(w);
    end
    send_byte(8'h03, 1'b0);
    send_byte(8'h00, 1'b0);
    for (int i = 0; i < 6; i++) send_byte(data_q[i], 1'b0);
    chk("partial_writes", 32'(exp_q.size()), 32'd0);
    reset = 1'b0;
    #1;
    check_reset_vals("midframe_reset");
    @(negedge clk);
    reset = 1'b1;
    exp_q.delete();

    fill_random(4 * 3);
    run_frame(3, 1'b0, 1'b1);
    do_reload();
    fill_random(4 * 4);
    run_frame(4, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
